// File: rtl/mem_burst_reader_pkg.sv
// rtl/mem_burst_reader_pkg.sv - shared state enum and default sizing for the burst reader
package mem_burst_reader_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_word_bank.sv
// rtl/mem_word_bank.sv - DEPTH x WIDTH storage, one write port, one combinational read port
module mem_word_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_wa,
    input  logic [WIDTH-1:0] i_wd,
    input  logic [AW-1:0]    i_ra,
    output logic [WIDTH-1:0] o_rd
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // No reset: contents survive a controller reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    // Reads see the pre-edge contents, so a same-edge write is not observed.
    assign o_rd = r_mem[i_ra];

endmodule

// File: rtl/mem_burst_reader.sv
// rtl/mem_burst_reader.sv - burst read engine over a word bank; MEM_BURST_READER_PARITY_EN adds QP
module mem_burst_reader
    import mem_burst_reader_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH),
    parameter int LW    = AW + 1
) (
    input  logic             C,
    input  logic             R,
    input  logic             WE,
    input  logic [AW-1:0]    WA,
    input  logic [WIDTH-1:0] WD,
    input  logic             RQ,
    input  logic [AW-1:0]    RA,
    input  logic [LW-1:0]    RL,
    output logic [WIDTH-1:0] Q,
    output logic             QV,
    input  logic             QR,
`ifdef MEM_BURST_READER_PARITY_EN
    output logic             QP,
`endif
    output logic             BSY,
    output logic             DN
);

    state_t           r_state;
    state_t           w_next_state;
    logic [AW-1:0]    r_ptr;
    logic [LW-1:0]    r_rem;
    logic [WIDTH-1:0] r_q;
    logic             r_qv;
    logic [AW-1:0]    w_rd_addr;
    logic [WIDTH-1:0] w_rd_data;
    logic             w_start;
    logic             w_beat;
    logic             w_last;

    assign w_start   = (r_state == IDLE) && RQ && (RL != '0);
    assign w_beat    = (r_state == SEND) && r_qv && QR;
    assign w_last    = (r_rem == LW'(1));
    // In IDLE the bank is addressed by the request so the first word lands with QV.
    assign w_rd_addr = (r_state == IDLE) ? RA : (r_ptr + AW'(1));

    mem_word_bank #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_bank (
        .i_clk (C),
        .i_we  (WE),
        .i_wa  (WA),
        .i_wd  (WD),
        .i_ra  (w_rd_addr),
        .o_rd  (w_rd_data)
    );

    always_ff @(posedge C) begin
        if (R) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (RQ) w_next_state = (RL != '0) ? SEND : DONE;
            SEND:    if (w_beat && w_last) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        BSY = (r_state != IDLE);
        DN  = (r_state == DONE);
    end

    always_ff @(posedge C) begin
        if (R) begin
            r_q   <= '0;
            r_qv  <= 1'b0;
            r_ptr <= '0;
            r_rem <= '0;
        end else if (w_start) begin
            r_ptr <= RA;
            r_rem <= RL;
            r_q   <= w_rd_data;
            r_qv  <= 1'b1;
        end else if (w_beat) begin
            if (!w_last) begin
                r_ptr <= w_rd_addr;
                r_q   <= w_rd_data;
                r_rem <= r_rem - LW'(1);
            end else begin
                r_qv  <= 1'b0;
                r_rem <= '0;
            end
        end
    end

    assign Q  = r_q;
    assign QV = r_qv;

`ifdef MEM_BURST_READER_PARITY_EN
    logic r_qp;

    always_ff @(posedge C) begin
        if (R) begin
            r_qp <= 1'b0;
        end else if (w_start || (w_beat && !w_last)) begin
            r_qp <= ^w_rd_data;
        end
    end

    assign QP = r_qp;
`endif

endmodule
